round_timer_ctrl: RTL
=====================

# round_timer_ctrl

Programmable interval timer controller that sequences an up-counter of `DATA_WIDTH` bits. It is used for game-round timeouts and LED display pacing in the Genius game logic. A prescaler divides `clk` into ticks, and each tick advances the count. The block supports one-shot and periodic modes with start/stop control, and raises single-cycle `tick` and `expired` events for the game FSM.

## Interface
- `DATA_WIDTH`, default 8: width of count and limit.
- `PRESCALE_WIDTH`, default 4: width of prescale config. Tick period is prescale+1 clocks.

- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cfg_limit`  in  DATA_WIDTH  terminal count. 0 means 2^DATA_WIDTH ticks.
- `cfg_prescale`  in  PRESCALE_WIDTH  clocks per tick minus 1.
- `cfg_periodic`  in  1  1 = auto-restart on expiry; 0 = one-shot.
- `start`  in  1  single-cycle request: latch config, clear, run.
- `stop`  in  1  single-cycle request: abort run, hold count.
- `count`  out  DATA_WIDTH  current tick count.
- `tick`  out  1  one-cycle pulse on each count update.
- `expired`  out  1  one-cycle pulse when count reaches limit.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE (one-shot completed).

## Operation
- FSM states: IDLE, RUN, DONE. Reset → IDLE.
- `start` (any state): latch `cfg_*` into `limit_q`, `pre_q`, `per_q`; count←0; prescaler←0; state←RUN.
  - `start` has priority over `stop` in the same cycle.
  - `start` in RUN is a restart.
- `stop` in RUN without `start`: state←IDLE, count holds, and no tick/expired is issued that cycle.
  - `stop` in IDLE or DONE is ignored.
- In RUN, the prescaler increments each clock. When prescaler == `pre_q`:
  - prescaler←0
  - next = count+1 (mod 2^DATA_WIDTH)
  - tick←1
- Expiry: next == `limit_q`.
  - Sets `expired`←1 with `tick` on the same edge.
  - One-shot: count←next and state←DONE.
  - Periodic: count←0 and state stays RUN.
- Non-expiring tick: count←next.
- `cfg_*` changes outside a `start` cycle have no effect on a run in progress.
- `limit_q` = 0: expiry on the wrap from all-ones to 0, after 2^DATA_WIDTH ticks. count then reads 0.
- All outputs are registered.

## Timing
- Reset values: `count`=0, `tick`=0, `expired`=0, `busy`=0, `done`=0, state IDLE, prescaler 0.
- Reset mid-run returns to these values immediately (async). Operation resumes only on a new `start`.
- `start` sampled at edge E0: `busy`=1 and `count`=0 visible after E0.
- First tick: `tick`=1 and count=1 visible after edge E0+(P+1), where P=`pre_q`. Later ticks follow every P+1 edges.
- One-shot, limit L≥1: `expired`, `tick`, and the DONE transition are all visible after edge E0+L·(P+1).
  - On that same edge `busy`→0 and `done`→1.
- Periodic: `expired` pulses every L·(P+1) clocks, with count→0 on the same edge.
- `stop` sampled at edge Es: `busy`=0 after Es. A tick due on Es is suppressed.
- `tick` and `expired` are exactly one cycle wide.

## Structure
- Package `timer_pkg`:
  - `typedef enum logic [1:0] {IDLE, RUN, DONE} timer_state_t`
  - default width localparams.
- Sub-module `tick_prescaler` with ports clk, rst_n, clear, enable, prescale → tick. It holds the prescaler register and compare.
- The top level holds the FSM, latched config, count register and output pulse registers.

## Test plan
- Reset then idle: hold `start`=0 for 20 clocks → `count`=0, `busy`=0, `done`=0, no `tick` or `expired`.
- One-shot, limit=3, prescale=1, start at E0:
  - ticks at E0+2, +4, +6.
  - `expired` and `done`=1 at E0+6.
  - count holds at 3 for 10 more clocks.
- Periodic, limit=2, prescale=0: `expired` at E0+2, +4, +6; count sequence 0,1,0,1,0.
- Stop and restart with limit=5, prescale=2:
  - `stop` at E0+7 leaves count=2 and `busy`=0, with no tick at the would-be E0+9.
  - `start` and `stop` together restart, giving count=0 and `busy`=1.
- Wrap with limit=0, DATA_WIDTH=8, prescale=0: exactly one `expired`, at E0+256, with count=0 and `done`=1.
- Async reset mid-run at count=4: all outputs return to 0 immediately. Changing `cfg_limit` mid-run (no `start`) does not change the expiry point.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and default widths for the round/LED interval timer.
package timer_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} timer_state_t;

  localparam int unsigned DEFAULT_DATA_WIDTH     = 8;
  localparam int unsigned DEFAULT_PRESCALE_WIDTH = 4;

endpackage

// File: rtl/round_timer_ctrl_tick_prescaler.sv
// Clock divider: raises tick on the clock where the running prescaler
// matches the configured prescale value, then wraps to zero.
module tick_prescaler
  import timer_pkg::*;
#(
  parameter int unsigned PRESCALE_WIDTH = DEFAULT_PRESCALE_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      enable,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      tick
);

  logic [PRESCALE_WIDTH-1:0] r_cnt;

  assign tick = enable && (r_cnt == prescale);

  // Prescaler register: clear wins over enable so a restart always begins at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable) begin
      if (r_cnt == prescale) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + PRESCALE_WIDTH'(1);
      end
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/round_timer_ctrl.sv
// Interval timer controller: IDLE/RUN/DONE sequencing of a tick counter
// with one-shot or periodic expiry, all event outputs registered.
module round_timer_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int unsigned PRESCALE_WIDTH = DEFAULT_PRESCALE_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_WIDTH-1:0]     cfg_limit,
  input  logic [PRESCALE_WIDTH-1:0] cfg_prescale,
  input  logic                      cfg_periodic,
  input  logic                      start,
  input  logic                      stop,
  output logic [DATA_WIDTH-1:0]     count,
  output logic                      tick,
  output logic                      expired,
  output logic                      busy,
  output logic                      done
);

  timer_state_t              r_state;
  timer_state_t              w_state_nxt;
  logic [DATA_WIDTH-1:0]     r_limit;
  logic [PRESCALE_WIDTH-1:0] r_pre;
  logic                      r_per;
  logic [DATA_WIDTH-1:0]     r_count;
  logic [DATA_WIDTH-1:0]     w_count_nxt;
  logic [DATA_WIDTH-1:0]     w_inc;
  logic                      r_tick;
  logic                      r_expired;
  logic                      r_busy;
  logic                      r_done;
  logic                      w_tick_nxt;
  logic                      w_expired_nxt;
  logic                      w_pre_tick;
  logic                      w_pre_enable;

  // A stop cycle freezes the prescaler so the tick due on that edge is dropped.
  assign w_pre_enable = (r_state == RUN) && !stop;

  tick_prescaler #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_prescaler (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (start),
    .enable  (w_pre_enable),
    .prescale(r_pre),
    .tick    (w_pre_tick)
  );

  // Next-state, next-count and event decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_tick_nxt    = 1'b0;
    w_expired_nxt = 1'b0;
    w_inc         = r_count + DATA_WIDTH'(1);
    if (start) begin
      w_state_nxt = RUN;
      w_count_nxt = '0;
    end else begin
      case (r_state)
        RUN: begin
          if (stop) begin
            w_state_nxt = IDLE;
          end else if (w_pre_tick) begin
            w_tick_nxt = 1'b1;
            // limit 0 matches on the wrap from all-ones, i.e. after 2^W ticks
            if (w_inc == r_limit) begin
              w_expired_nxt = 1'b1;
              if (r_per) begin
                w_count_nxt = '0;
              end else begin
                w_count_nxt = w_inc;
                w_state_nxt = DONE;
              end
            end else begin
              w_count_nxt = w_inc;
            end
          end else begin
            w_count_nxt = r_count;
          end
        end
        IDLE:    w_state_nxt = IDLE;
        DONE:    w_state_nxt = DONE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // State, latched configuration, count and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_limit   <= '0;
      r_pre     <= '0;
      r_per     <= 1'b0;
      r_count   <= '0;
      r_tick    <= 1'b0;
      r_expired <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      if (start) begin
        r_limit <= cfg_limit;
        r_pre   <= cfg_prescale;
        r_per   <= cfg_periodic;
      end
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_tick    <= w_tick_nxt;
      r_expired <= w_expired_nxt;
      r_busy    <= (w_state_nxt == RUN);
      r_done    <= (w_state_nxt == DONE);
    end
  end

  assign count   = r_count;
  assign tick    = r_tick;
  assign expired = r_expired;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule
